// File: rtl/mux_scan_n.sv
// mux_scan_n -- N-channel, WIDTH-bit registered multiplexer.
//
// Manual mode copies the directly selected channel to the output every
// enabled cycle. Scan mode steps through channels 0..N-1 in round-robin
// order and holds each one for DWELL enabled cycles. Data is re-sampled every
// enabled cycle, so changes within a dwell show up. There is no combinational
// path from din to out.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; release takes effect on the next edge
//   din        packed channels, channel k = din[k*WIDTH +: WIDTH]
//   sel        manual channel select; values >= N are ignored
//   mode       0 = manual, 1 = scan
//   en         global enable; low freezes all state and forces wrap low
//   out        registered selected data
//   cur_sel    index of the channel currently driving out
//   valid      out holds data captured since reset
//   wrap       one-cycle pulse when scan steps from channel N-1 to 0
//   dbg_state  current FSM state (0 = IDLE, 1 = MANUAL, 2 = SCAN)
module mux_scan_n #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] din,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  input  logic               en,
  output logic [WIDTH-1:0]   out,
  output logic [SELW-1:0]    cur_sel,
  output logic               valid,
  output logic               wrap,
  output logic [1:0]         dbg_state
);

  localparam int DW = $clog2(DWELL) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WIDTH-1:0]  r_out;
  logic [WIDTH-1:0]  w_next_out;
  logic [SELW-1:0]   r_sel;
  logic [SELW-1:0]   w_next_sel;
  logic [DW-1:0]     r_dwell;
  logic [DW-1:0]     w_next_dwell;
  logic              r_valid;
  logic              w_next_valid;
  logic              r_wrap;
  logic              w_next_wrap;
  logic              w_sel_ok;

  // The channel table is padded to the full select range so any SELW-bit
  // index is in bounds; padding entries are never chosen because manual
  // selects are range-checked against N and scan wraps at N-1.
  logic [WIDTH-1:0]  w_ch [2**SELW];

  for (genvar k = 0; k < 2**SELW; k++) begin : g_ch
    if (k < N) begin : g_real
      assign w_ch[k] = din[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_ch[k] = '0;
    end
  end

  assign w_sel_ok = (int'(sel) < N);

  // Next-state: with en high the mode input alone picks the state; entry
  // rules for SCAN are handled in the datapath by looking at r_state.
  always_comb begin
    w_next_state = r_state;
    if (en) begin
      w_next_state = mode ? ST_SCAN : ST_MANUAL;
    end
  end

  always_comb begin
    w_next_out   = r_out;
    w_next_sel   = r_sel;
    w_next_dwell = r_dwell;
    w_next_valid = r_valid;
    w_next_wrap  = 1'b0;
    if (en) begin
      w_next_valid = 1'b1;
      if (!mode) begin
        // Manual (also wins over a dwell expiry on the same edge).
        w_next_dwell = '0;
        if (w_sel_ok) begin
          w_next_sel = sel;
        end
      end else if (r_state != ST_SCAN) begin
        // Scan entry always restarts at channel 0 without a wrap pulse.
        w_next_sel   = '0;
        w_next_dwell = '0;
      end else if (r_dwell == DW'(DWELL - 1)) begin
        w_next_dwell = '0;
        if (r_sel == SELW'(N - 1)) begin
          w_next_sel  = '0;
          w_next_wrap = 1'b1;
        end else begin
          w_next_sel = r_sel + SELW'(1);
        end
      end else begin
        w_next_dwell = r_dwell + DW'(1);
      end
      // Out follows the new index every enabled edge, except an ignored
      // out-of-range manual select, which holds both out and cur_sel.
      if (mode || w_sel_ok) begin
        w_next_out = w_ch[w_next_sel];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_sel   <= '0;
      r_dwell <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_out   <= w_next_out;
      r_sel   <= w_next_sel;
      r_dwell <= w_next_dwell;
      r_valid <= w_next_valid;
      r_wrap  <= w_next_wrap;
    end
  end

  assign out       = r_out;
  assign cur_sel   = r_sel;
  assign valid     = r_valid;
  assign wrap      = r_wrap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_scan_n.sv
module tb_mux_scan_n;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT A: N=4, DWELL=3 ----------------
  logic [15:0] din_a;
  logic [1:0]  sel_a;
  logic        mode_a, en_a;
  logic [3:0]  out_a;
  logic [1:0]  cur_sel_a;
  logic        valid_a, wrap_a;
  logic [1:0]  dbg_state_a;

  mux_scan_n #(.WIDTH(4), .N(4), .SELW(2), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .sel(sel_a), .mode(mode_a),
    .en(en_a), .out(out_a), .cur_sel(cur_sel_a), .valid(valid_a),
    .wrap(wrap_a), .dbg_state(dbg_state_a)
  );

  // ---------------- DUT B: N=3 (non power of 2), DWELL=1 ----------------
  logic [11:0] din_b;
  logic [1:0]  sel_b;
  logic        mode_b, en_b;
  logic [3:0]  out_b;
  logic [1:0]  cur_sel_b;
  logic        valid_b, wrap_b;
  logic [1:0]  dbg_state_b;

  mux_scan_n #(.WIDTH(4), .N(3), .SELW(2), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .sel(sel_b), .mode(mode_b),
    .en(en_b), .out(out_b), .cur_sel(cur_sel_b), .valid(valid_b),
    .wrap(wrap_b), .dbg_state(dbg_state_b)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] e_out, input logic [1:0] e_sel,
                         input logic e_wrap);
    check({tag, ".out"},     out_a,     e_out);
    check({tag, ".cur_sel"}, cur_sel_a, e_sel);
    check({tag, ".wrap"},    wrap_a,    e_wrap);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] exp_ch [4];
    int idx;
    exp_ch[0] = 4'hA; exp_ch[1] = 4'hB; exp_ch[2] = 4'hC; exp_ch[3] = 4'hD;

    rst_n  = 1'b1;
    din_a  = 16'hDCBA; sel_a = 2'd0; mode_a = 1'b0; en_a = 1'b0;
    din_b  = 12'h987;  sel_b = 2'd0; mode_b = 1'b0; en_b = 1'b0;
    #2 rst_n = 1'b0;

    // Reset state
    repeat (2) tick();
    check_a("rst", 4'h0, 2'd0, 1'b0);
    check("rst.valid", valid_a, 1'b0);
    check("rst.state", dbg_state_a, 2'd0);

    // Manual mode: sel 0..3 -> A..D one cycle later
    rst_n = 1'b1; en_a = 1'b1; mode_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel_a = i[1:0];
      tick();
      check_a($sformatf("man%0d", i), exp_ch[i], i[1:0], 1'b0);
      check("man.valid", valid_a, 1'b1);
    end

    // Scan period: entry A, then each channel 3 cycles, wrap on cycle 12
    mode_a = 1'b1;
    tick();
    check_a("scan_entry", 4'hA, 2'd0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      idx = (i / 3) % 4;
      check_a($sformatf("scan%0d", i), exp_ch[idx], idx[1:0], i == 12);
    end

    // Enable freeze on B with dwell=1
    mode_a = 1'b0; tick();
    mode_a = 1'b1; tick();            // entry: A dwell 0
    repeat (3) tick();                // B dwell 0
    tick();                           // B dwell 1
    check_a("pre_freeze", 4'hB, 2'd1, 1'b0);
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_a($sformatf("freeze%0d", i), 4'hB, 2'd1, 1'b0);
    end
    en_a = 1'b1;
    tick();
    check_a("thaw_b", 4'hB, 2'd1, 1'b0);
    tick();
    check_a("thaw_c", 4'hC, 2'd2, 1'b0);

    // Mode switch on the expiry edge of channel 3 (would otherwise wrap)
    repeat (3) tick();                // D dwell 0
    repeat (2) tick();                // D dwell 2
    check_a("pre_switch", 4'hD, 2'd3, 1'b0);
    mode_a = 1'b0; sel_a = 2'd3;
    tick();
    check_a("switch_man", 4'hD, 2'd3, 1'b0);
    check("switch.state", dbg_state_a, 2'd1);
    mode_a = 1'b1;
    tick();
    check_a("switch_scan", 4'hA, 2'd0, 1'b0);

    // Async reset mid-scan at cur_sel=2
    repeat (6) tick();
    check_a("pre_rst", 4'hC, 2'd2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_a("async_rst", 4'h0, 2'd0, 1'b0);
    check("async_rst.valid", valid_a, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check_a("post_rst", 4'hA, 2'd0, 1'b0);
    check("post_rst.valid", valid_a, 1'b1);
    tick();
    check_a("post_rst2", 4'hA, 2'd0, 1'b0);

    // Non-power-of-2 channel count: out-of-range select holds
    en_a = 1'b0;
    check("b.valid_idle", valid_b, 1'b0);
    en_b = 1'b1; mode_b = 1'b0; sel_b = 2'd2;
    tick();
    check("b.sel2.out", out_b, 4'h9);
    check("b.sel2.cur", cur_sel_b, 2'd2);
    sel_b = 2'd3;
    tick();
    check("b.sel3.out", out_b, 4'h9);
    check("b.sel3.cur", cur_sel_b, 2'd2);
    sel_b = 2'd1;
    tick();
    check("b.sel1.out", out_b, 4'h8);

    // DWELL=1 scan: 0,1,2,0,1 with wrap on 2->0
    mode_b = 1'b1;
    tick();
    check("b.entry.cur", cur_sel_b, 2'd0);
    check("b.entry.out", out_b, 4'h7);
    check("b.entry.wrap", wrap_b, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      idx = i % 3;
      check($sformatf("b.scan%0d.cur", i), cur_sel_b, idx[1:0]);
      check($sformatf("b.scan%0d.out", i), out_b, 4'h7 + idx[3:0]);
      check($sformatf("b.scan%0d.wrap", i), wrap_b, i == 3);
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
